// File: rtl/serial_tx.sv
// serial_tx: 8051-style UART transmitter for SCON modes 1/2/3.
// Ports: system_clk_i/system_rst_i (sync, active-high), serial_tx_sm0_i/
//   serial_tx_sm1_i mode, serial_tx_tb8_i ninth bit, serial_tx_br_trans_i bit
//   tick, serial_tx_sbuf_wr_i/serial_tx_sbuf_data_i SBUF write,
//   serial_tx_ti_clr_i TI clear; serial_tx_txd_o line, serial_tx_ti_o TI flag,
//   serial_tx_busy_o frame in progress. All outputs registered.
module serial_tx (
  input  logic       system_clk_i,
  input  logic       system_rst_i,
  input  logic       serial_tx_sm0_i,
  input  logic       serial_tx_sm1_i,
  input  logic       serial_tx_tb8_i,
  input  logic       serial_tx_br_trans_i,
  input  logic       serial_tx_sbuf_wr_i,
  input  logic [7:0] serial_tx_sbuf_data_i,
  input  logic       serial_tx_ti_clr_i,
  output logic       serial_tx_txd_o,
  output logic       serial_tx_ti_o,
  output logic       serial_tx_busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    NINTH,
    STOP
  } state_e;

  state_e     state_q, state_d;
  logic       armed_q, armed_d;
  logic [7:0] data_q, data_d;
  logic       tb8_q, tb8_d;
  logic       nine_q, nine_d;
  logic [2:0] cnt_q, cnt_d;
  logic       txd_q, txd_d;
  logic       ti_q, ti_d;
  logic       busy_q, busy_d;

  logic       tick;
  logic       mode_tx;

  assign tick    = serial_tx_br_trans_i;
  // Mode 0 (shift-register mode) is not handled here; writes are dropped.
  assign mode_tx = serial_tx_sm0_i | serial_tx_sm1_i;

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    data_d  = data_q;
    tb8_d   = tb8_q;
    nine_d  = nine_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    ti_d    = ti_q;
    if (serial_tx_ti_clr_i) begin
      ti_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (!armed_q) begin
          // The tick on the accepting edge is deliberately not consumed.
          if (serial_tx_sbuf_wr_i && mode_tx) begin
            armed_d = 1'b1;
            busy_d  = 1'b1;
            data_d  = serial_tx_sbuf_data_i;
            tb8_d   = serial_tx_tb8_i;
            nine_d  = serial_tx_sm0_i;
          end
        end else if (tick) begin
          state_d = START;
          armed_d = 1'b0;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = 3'd0;
          txd_d   = data_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
            if (nine_q) begin
              state_d = NINTH;
              txd_d   = tb8_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
              ti_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            txd_d = data_q[cnt_q + 3'd1];
          end
        end
      end
      NINTH: begin
        if (tick) begin
          state_d = STOP;
          txd_d   = 1'b1;
          ti_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        armed_d = 1'b0;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge system_clk_i) begin
    if (system_rst_i) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      data_q  <= 8'h00;
      tb8_q   <= 1'b0;
      nine_q  <= 1'b0;
      cnt_q   <= 3'd0;
      txd_q   <= 1'b1;
      ti_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      tb8_q   <= tb8_d;
      nine_q  <= nine_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      ti_q    <= ti_d;
      busy_q  <= busy_d;
    end
  end

  assign serial_tx_txd_o  = txd_q;
  assign serial_tx_ti_o   = ti_q;
  assign serial_tx_busy_o = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed + randomized bench for serial_tx.
// Frames are predicted as bit lists built from the UART framing rules.
module tb_serial_tx;

  logic       clk;
  logic       rst;
  logic       sm0, sm1, tb8, br, wr, ti_clr;
  logic [7:0] din;
  logic       txd, ti, busy;

  int total = 0;
  int bad   = 0;
  logic ti_exp = 1'b0;

  serial_tx dut (
    .system_clk_i          (clk),
    .system_rst_i          (rst),
    .serial_tx_sm0_i       (sm0),
    .serial_tx_sm1_i       (sm1),
    .serial_tx_tb8_i       (tb8),
    .serial_tx_br_trans_i  (br),
    .serial_tx_sbuf_wr_i   (wr),
    .serial_tx_sbuf_data_i (din),
    .serial_tx_ti_clr_i    (ti_clr),
    .serial_tx_txd_o       (txd),
    .serial_tx_ti_o        (ti),
    .serial_tx_busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge; the TI model follows set-beats-clear, reset-beats-all.
  task automatic step(input bit set_ti);
    @(posedge clk);
    if (rst) ti_exp = 1'b0;
    else if (set_ti) ti_exp = 1'b1;
    else if (ti_clr) ti_exp = 1'b0;
    #1;
  endtask

  task automatic tick_after(input int p);
    for (int j = 1; j < p; j++) step(0);
    br = 1'b1;
    step(0);
    br = 1'b0;
  endtask

  // clr_mode: 0 none, 1 clear on the TI-set edge, 2 clear one cycle later.
  task automatic run_frame(input logic [1:0] m, input logic [7:0] d,
                           input logic t8, input int p, input bit wr_on_tick,
                           input bit noisy, input int clr_mode,
                           input bit late_wr);
    logic bits[$];
    logic line;
    int   nb;
    bits.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (m[1]) bits.push_back(t8);
    bits.push_back(1'b1);
    nb = bits.size();
    sm0 = m[1]; sm1 = m[0]; tb8 = t8; din = d; wr = 1'b1; br = wr_on_tick;
    step(0);
    wr = 1'b0; br = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_txd", txd, 1'b1);
    line = 1'b1;
    for (int k = 0; k <= nb; k++) begin
      bit enter_stop;
      enter_stop = (k == nb - 1);
      for (int j = 1; j < p; j++) begin
        if (noisy) begin
          sm0 = 1'($urandom); sm1 = 1'($urandom); tb8 = 1'($urandom);
          din = 8'($urandom);
          wr  = ($urandom_range(0, 3) == 0);
        end
        if (late_wr && k == 3 && j == 1) begin
          din = 8'hFF; wr = 1'b1;
        end
        step(0);
        wr = 1'b0;
        if (j == p / 2) begin
          chk("mid_txd", txd, line);
          chk("mid_busy", busy, 1'b1);
        end
      end
      br = 1'b1;
      ti_clr = (enter_stop && clr_mode == 1);
      step(enter_stop);
      br = 1'b0; ti_clr = 1'b0;
      if (k < nb) begin
        line = bits[k];
        chk("bit_txd", txd, line);
        chk("bit_busy", busy, 1'b1);
        chk("bit_ti", ti, ti_exp);
      end else begin
        chk("end_busy", busy, 1'b0);
        chk("end_txd", txd, 1'b1);
        chk("end_ti", ti, ti_exp);
      end
      if (enter_stop) begin
        chk("ti_set", ti, 1'b1);
        if (clr_mode == 2) begin
          ti_clr = 1'b1;
          step(0);
          ti_clr = 1'b0;
          chk("ti_clr_late", ti, 1'b0);
        end
      end
    end
    if (ti_exp) begin
      ti_clr = 1'b1;
      step(0);
      ti_clr = 1'b0;
      chk("ti_clear", ti, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; sm0 = 1'b0; sm1 = 1'b0; tb8 = 1'b0; br = 1'b0;
    wr = 1'b0; ti_clr = 1'b0; din = 8'h00;
    step(0);
    step(0);
    chk("rst_txd", txd, 1'b1);
    chk("rst_ti", ti, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Idle ticks with nothing pending change nothing.
    for (int i = 0; i < 3; i++) begin
      tick_after(2);
      chk("idle_txd", txd, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end

    run_frame(2'b01, 8'hA5, 1'b0, 16, 1'b0, 1'b0, 0, 1'b0);
    run_frame(2'b11, 8'h3C, 1'b1, 4, 1'b0, 1'b0, 0, 1'b0);
    run_frame(2'b10, 8'h3C, 1'b0, 4, 1'b0, 1'b0, 0, 1'b0);
    run_frame(2'b01, 8'h55, 1'b0, 6, 1'b0, 1'b0, 0, 1'b1);
    run_frame(2'b01, 8'hC3, 1'b0, 5, 1'b1, 1'b0, 0, 1'b0);
    run_frame(2'b11, 8'h81, 1'b0, 4, 1'b0, 1'b0, 1, 1'b0);
    run_frame(2'b01, 8'h7E, 1'b1, 4, 1'b0, 1'b0, 2, 1'b0);

    // Abort during data bit 4.
    d = 8'($urandom);
    sm0 = 1'b0; sm1 = 1'b1; din = d; wr = 1'b1;
    step(0);
    wr = 1'b0;
    for (int i = 0; i < 6; i++) tick_after(4);
    chk("pre_abort_txd", txd, d[4]);
    step(0);
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    chk("abort_txd", txd, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ti", ti, 1'b0);
    sm0 = 1'b0; sm1 = 1'b0; din = 8'h00; wr = 1'b1;
    step(0);
    wr = 1'b0;
    chk("m0_txd", txd, 1'b1);
    chk("m0_busy", busy, 1'b0);
    chk("m0_ti", ti, 1'b0);
    tick_after(3);
    tick_after(3);
    chk("m0_tick_txd", txd, 1'b1);
    chk("m0_tick_busy", busy, 1'b0);

    run_frame(2'b01, 8'h0F, 1'b0, 3, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      run_frame(m, 8'($urandom), 1'($urandom), int'($urandom_range(2, 12)),
                1'($urandom), 1'b1, int'($urandom_range(0, 2)), 1'b0);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) step(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
